// File: rtl/csm_stim_gen.sv
// csm_stim_gen: stimulus sequencer for the CSM shared-memory DUT.
// A 64-bit LFSR chooses a scenario, two ports (A, B) with their addresses and data for each
// iteration. A directed mode instead replays one scenario from the dir_* inputs. The ops of
// each scenario step are issued as per-port valid/ready handshakes.
//
// Ports:
//   clk, reset        clock and synchronous active-high reset
//   start             begin a run (sampled in IDLE or DONE)
//   mode_dir          directed mode select (sampled in DRAW)
//   dir_scn           directed scenario index
//   dir_a/b_addr/data directed addresses and data
//   op_valid/op_ready per-port handshake
//   op_code           per port 3 bits: 0 NOP, 1 READ, 2 WRITE, 3 HOLD, 4 RELEASE
//   op_addr, op_data  per-port address and data
//   busy, done        run status
//   iter_count        completed iterations
module csm_stim_gen #(
  parameter int unsigned NPORTS = 2,
  parameter int unsigned AW     = 2,
  parameter int unsigned DW     = 8,
  parameter int unsigned ITER   = 1000,
  parameter logic [63:0] SEED   = 64'h1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   mode_dir,
  input  logic [3:0]             dir_scn,
  input  logic [AW-1:0]          dir_a_addr,
  input  logic [AW-1:0]          dir_b_addr,
  input  logic [DW-1:0]          dir_a_data,
  input  logic [DW-1:0]          dir_b_data,
  output logic [NPORTS-1:0]      op_valid,
  input  logic [NPORTS-1:0]      op_ready,
  output logic [3*NPORTS-1:0]    op_code,
  output logic [AW*NPORTS-1:0]   op_addr,
  output logic [DW*NPORTS-1:0]   op_data,
  output logic                   busy,
  output logic                   done,
  output logic [15:0]            iter_count
);

  localparam int unsigned PW = $clog2(NPORTS);
  localparam logic [63:0] SeedEff = (SEED == 64'h0) ? 64'h1 : SEED;
  localparam logic [15:0] IterMax = 16'(ITER);

  // Field offsets within the post-advance LFSR word.
  localparam int unsigned OffAAddr = 4;
  localparam int unsigned OffACls  = OffAAddr + AW;
  localparam int unsigned OffARnd  = OffACls + 2;
  localparam int unsigned OffBAddr = OffARnd + DW;
  localparam int unsigned OffBCls  = OffBAddr + AW;
  localparam int unsigned OffBRnd  = OffBCls + 2;
  localparam int unsigned OffPa    = OffBRnd + DW;
  localparam int unsigned OffOff   = OffPa + PW;

  localparam logic [2:0] OpNop  = 3'd0;
  localparam logic [2:0] OpRead = 3'd1;
  localparam logic [2:0] OpWr   = 3'd2;
  localparam logic [2:0] OpHold = 3'd3;
  localparam logic [2:0] OpRel  = 3'd4;

  typedef enum logic [1:0] {StIdle, StDraw, StStep, StDone} state_e;

  // Returns {a_op, b_op} for step s of scenario scn.
  function automatic logic [5:0] step_ops(input logic [3:0] scn, input logic [1:0] s);
    logic [2:0] a, b;
    a = OpNop;
    b = OpNop;
    case (scn)
      4'd0:  if (s == 2'd0) a = OpRead;
      4'd1:  if (s == 2'd0) a = OpWr;
      4'd2:  if (s == 2'd0) b = OpWr;
      4'd3:  if (s == 2'd0) b = OpRead;
      4'd4:  begin if (s == 2'd0) a = OpRead; if (s == 2'd1) b = OpRead; end
      4'd5:  begin if (s == 2'd0) a = OpRead; if (s == 2'd1) b = OpWr;   end
      4'd6:  begin if (s == 2'd0) a = OpWr;   if (s == 2'd1) b = OpRead; end
      4'd7:  if (s == 2'd0) begin a = OpHold; b = OpRead; end
      4'd8:  if (s == 2'd0) begin a = OpRead; b = OpHold; end
      4'd9:  begin
        if (s == 2'd0) a = OpHold;
        if (s == 2'd1) a = OpRel;
        if (s == 2'd2) b = OpRead;
      end
      4'd10: begin if (s == 2'd0) a = OpRead; if (s == 2'd1) a = OpRead; end
      4'd11: begin if (s == 2'd0) a = OpWr;   if (s == 2'd1) a = OpWr;   end
      4'd12: begin if (s == 2'd0) a = OpWr;   if (s == 2'd1) a = OpRead; end
      4'd13: if (s == 2'd0) begin a = OpWr; b = OpWr; end
      4'd14: if (s == 2'd0) begin a = OpHold; b = OpHold; end
      default: begin if (s == 2'd0) a = OpHold; if (s == 2'd1) b = OpHold; end
    endcase
    return {a, b};
  endfunction

  function automatic logic [1:0] last_step(input logic [3:0] scn);
    case (scn)
      4'd4, 4'd5, 4'd6, 4'd10, 4'd11, 4'd12, 4'd15: return 2'd1;
      4'd9:                                         return 2'd2;
      default:                                      return 2'd0;
    endcase
  endfunction

  function automatic logic [DW-1:0] cls_data(input logic [1:0] cls, input logic [DW-1:0] rnd);
    case (cls)
      2'b00:   return '0;
      2'b01:   return '1;
      default: return rnd;
    endcase
  endfunction

  state_e              state_q;
  logic [1:0]          s_q;
  logic [63:0]         lfsr_q;
  logic [15:0]         iter_q;
  logic [3:0]          scn_q;
  logic [PW-1:0]       pa_q, pb_q;
  logic [AW-1:0]       a_addr_q, b_addr_q;
  logic [DW-1:0]       a_data_q, b_data_q;
  logic [NPORTS-1:0]   op_valid_q;
  logic [3*NPORTS-1:0] op_code_q;
  logic [AW*NPORTS-1:0] op_addr_q;
  logic [DW*NPORTS-1:0] op_data_q;
  logic                busy_q, done_q;

  logic                fb;
  logic [63:0]         lfsr_adv;
  logic [3:0]          dr_scn, ld_scn;
  logic [PW-1:0]       dr_pa, dr_pb, dr_off, ld_pa, ld_pb;
  logic [AW-1:0]       dr_a_addr, dr_b_addr, ld_a_addr, ld_b_addr;
  logic [DW-1:0]       dr_a_data, dr_b_data, ld_a_data, ld_b_data;
  logic [1:0]          ld_s;
  logic [2:0]          ld_a_op, ld_b_op;
  logic [NPORTS-1:0]   nx_valid, accepted, remaining;
  logic [3*NPORTS-1:0] nx_code;
  logic [AW*NPORTS-1:0] nx_addr;
  logic [DW*NPORTS-1:0] nx_data;

  always_comb begin
    fb       = lfsr_q[63] ^ lfsr_q[62] ^ lfsr_q[60] ^ lfsr_q[59];
    lfsr_adv = {lfsr_q[62:0], fb};

    dr_off    = lfsr_adv[OffOff +: PW];
    dr_scn    = lfsr_adv[3:0];
    dr_a_addr = lfsr_adv[OffAAddr +: AW];
    dr_b_addr = lfsr_adv[OffBAddr +: AW];
    dr_a_data = cls_data(lfsr_adv[OffACls +: 2], lfsr_adv[OffARnd +: DW]);
    dr_b_data = cls_data(lfsr_adv[OffBCls +: 2], lfsr_adv[OffBRnd +: DW]);
    dr_pa     = lfsr_adv[OffPa +: PW];
    // Zero offset would alias B onto A, so it is forced to 1.
    dr_pb     = dr_pa ^ ((dr_off == '0) ? PW'(1) : dr_off);
    if (mode_dir) begin
      dr_scn    = dir_scn;
      dr_a_addr = dir_a_addr;
      dr_b_addr = dir_b_addr;
      dr_a_data = dir_a_data;
      dr_b_data = dir_b_data;
      dr_pa     = '0;
      dr_pb     = PW'(1);
    end

    // In DRAW the first step comes from the fresh draw; in STEP the next step from the latch.
    if (state_q == StDraw) begin
      ld_scn = dr_scn;   ld_s = 2'd0;
      ld_pa = dr_pa;     ld_pb = dr_pb;
      ld_a_addr = dr_a_addr; ld_b_addr = dr_b_addr;
      ld_a_data = dr_a_data; ld_b_data = dr_b_data;
    end else begin
      ld_scn = scn_q;    ld_s = s_q + 2'd1;
      ld_pa = pa_q;      ld_pb = pb_q;
      ld_a_addr = a_addr_q; ld_b_addr = b_addr_q;
      ld_a_data = a_data_q; ld_b_data = b_data_q;
    end
    {ld_a_op, ld_b_op} = step_ops(ld_scn, ld_s);

    nx_valid = '0;
    nx_code  = '0;
    nx_addr  = '0;
    nx_data  = '0;
    for (int p = 0; p < int'(NPORTS); p++) begin
      if (ld_a_op != OpNop && ld_pa == PW'(p)) begin
        nx_valid[p]         = 1'b1;
        nx_code[p*3 +: 3]   = ld_a_op;
        nx_addr[p*AW +: AW] = ld_a_addr;
        nx_data[p*DW +: DW] = ld_a_data;
      end else if (ld_b_op != OpNop && ld_pb == PW'(p)) begin
        nx_valid[p]         = 1'b1;
        nx_code[p*3 +: 3]   = ld_b_op;
        nx_addr[p*AW +: AW] = ld_b_addr;
        nx_data[p*DW +: DW] = ld_b_data;
      end
    end

    accepted  = op_valid_q & op_ready;
    remaining = op_valid_q & ~op_ready;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      s_q        <= 2'd0;
      lfsr_q     <= SeedEff;
      iter_q     <= 16'd0;
      scn_q      <= 4'd0;
      pa_q       <= '0;
      pb_q       <= '0;
      a_addr_q   <= '0;
      b_addr_q   <= '0;
      a_data_q   <= '0;
      b_data_q   <= '0;
      op_valid_q <= '0;
      op_code_q  <= '0;
      op_addr_q  <= '0;
      op_data_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q <= StDraw;
            busy_q  <= 1'b1;
          end
        end
        StDone: begin
          if (start) begin
            state_q <= StDraw;
            iter_q  <= 16'd0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
          end
        end
        StDraw: begin
          lfsr_q     <= lfsr_adv;
          scn_q      <= ld_scn;
          pa_q       <= ld_pa;
          pb_q       <= ld_pb;
          a_addr_q   <= ld_a_addr;
          b_addr_q   <= ld_b_addr;
          a_data_q   <= ld_a_data;
          b_data_q   <= ld_b_data;
          s_q        <= 2'd0;
          op_valid_q <= nx_valid;
          op_code_q  <= nx_code;
          op_addr_q  <= nx_addr;
          op_data_q  <= nx_data;
          state_q    <= StStep;
        end
        StStep: begin
          if (remaining == '0) begin
            if (s_q == last_step(scn_q)) begin
              iter_q     <= iter_q + 16'd1;
              op_valid_q <= '0;
              op_code_q  <= '0;
              op_addr_q  <= '0;
              op_data_q  <= '0;
              if (iter_q + 16'd1 == IterMax) begin
                state_q <= StDone;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end else begin
                state_q <= StDraw;
              end
            end else begin
              s_q        <= s_q + 2'd1;
              op_valid_q <= nx_valid;
              op_code_q  <= nx_code;
              op_addr_q  <= nx_addr;
              op_data_q  <= nx_data;
            end
          end else begin
            // Retire accepted ports individually; the rest stay stable.
            for (int p = 0; p < int'(NPORTS); p++) begin
              if (accepted[p]) begin
                op_valid_q[p]         <= 1'b0;
                op_code_q[p*3 +: 3]   <= OpNop;
                op_addr_q[p*AW +: AW] <= '0;
                op_data_q[p*DW +: DW] <= '0;
              end
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign op_valid   = op_valid_q;
  assign op_code    = op_code_q;
  assign op_addr    = op_addr_q;
  assign op_data    = op_data_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign iter_count = iter_q;

endmodule

// File: tb/tb_csm_stim_gen.sv
module tb_csm_stim_gen;

  localparam logic [63:0] Seed1 = 64'h0123_4567_89AB_CDEF;
  localparam logic [2:0] N = 3'd0, R = 3'd1, W = 3'd2, H = 3'd3, L = 3'd4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start0 = 1'b0, start1 = 1'b0;
  logic        mode_dir0 = 1'b0, mode_dir1 = 1'b0;
  logic [3:0]  dir_scn = 4'd0;
  logic [1:0]  dir_a_addr = 2'd0, dir_b_addr = 2'd0;
  logic [7:0]  dir_a_data = 8'd0, dir_b_data = 8'd0;

  logic [1:0]  v0, rdy0;
  logic [5:0]  c0;
  logic [3:0]  a0;
  logic [15:0] d0;
  logic        busy0, done0;
  logic [15:0] it0;

  logic [3:0]  v1, rdy1;
  logic [11:0] c1;
  logic [7:0]  a1;
  logic [31:0] d1;
  logic        busy1, done1;
  logic [15:0] it1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  csm_stim_gen #(.NPORTS(2), .AW(2), .DW(8), .ITER(1), .SEED(64'h1)) dut0 (
    .clk(clk), .reset(reset), .start(start0), .mode_dir(mode_dir0), .dir_scn(dir_scn),
    .dir_a_addr(dir_a_addr), .dir_b_addr(dir_b_addr),
    .dir_a_data(dir_a_data), .dir_b_data(dir_b_data),
    .op_valid(v0), .op_ready(rdy0), .op_code(c0), .op_addr(a0), .op_data(d0),
    .busy(busy0), .done(done0), .iter_count(it0)
  );

  csm_stim_gen #(.NPORTS(4), .AW(2), .DW(8), .ITER(200), .SEED(Seed1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .mode_dir(mode_dir1), .dir_scn(dir_scn),
    .dir_a_addr(dir_a_addr), .dir_b_addr(dir_b_addr),
    .dir_a_data(dir_a_data), .dir_b_data(dir_b_data),
    .op_valid(v1), .op_ready(rdy1), .op_code(c1), .op_addr(a1), .op_data(d1),
    .busy(busy1), .done(done1), .iter_count(it1)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; the bench always sits at the falling edge.
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pulse0();
    start0 = 1'b1;
    cyc();
    start0 = 1'b0;
  endtask

  // Scenario table: {nsteps, s2a, s2b, s1a, s1b, s0a, s0b}.
  function automatic logic [19:0] scn_tab(input logic [3:0] n);
    case (n)
      4'd0:  return {2'd1, N, N, N, N, R, N};
      4'd1:  return {2'd1, N, N, N, N, W, N};
      4'd2:  return {2'd1, N, N, N, N, N, W};
      4'd3:  return {2'd1, N, N, N, N, N, R};
      4'd4:  return {2'd2, N, N, N, R, R, N};
      4'd5:  return {2'd2, N, N, N, W, R, N};
      4'd6:  return {2'd2, N, N, N, R, W, N};
      4'd7:  return {2'd1, N, N, N, N, H, R};
      4'd8:  return {2'd1, N, N, N, N, R, H};
      4'd9:  return {2'd3, N, R, L, N, H, N};
      4'd10: return {2'd2, N, N, R, N, R, N};
      4'd11: return {2'd2, N, N, W, N, W, N};
      4'd12: return {2'd2, N, N, R, N, W, N};
      4'd13: return {2'd1, N, N, N, N, W, W};
      4'd14: return {2'd1, N, N, N, N, H, H};
      default: return {2'd2, N, N, N, H, H, N};
    endcase
  endfunction

  function automatic logic [7:0] map_data(input logic [1:0] cls, input logic [7:0] rnd);
    if (cls == 2'b00) return 8'h00;
    if (cls == 2'b01) return 8'hFF;
    return rnd;
  endfunction

  logic [63:0] m;
  logic [19:0] tab;
  logic [3:0]  scn;
  logic [1:0]  aa, ba, pa, pb, off;
  logic [7:0]  ad, bd;
  logic [2:0]  ac, bc;
  logic [3:0]  ev, outm;
  logic [11:0] ecode, cm;
  logic [7:0]  eaddr, am;
  logic [31:0] edata, dm;
  int          nst, waitc;
  bit          abort;

  initial begin
    rdy0 = 2'b11;
    rdy1 = 4'hF;
    cyc();
    cyc();
    reset = 1'b0;

    // Reset values, held while idle.
    for (int i = 0; i < 5; i++) begin
      chk("rst_valid", v0, 0);
      chk("rst_code", c0, 0);
      chk("rst_addr", a0, 0);
      chk("rst_data", d0, 0);
      chk("rst_busy", busy0, 0);
      chk("rst_done", done0, 0);
      chk("rst_iter", it0, 0);
      cyc();
    end

    // First random draw from seed 1: LFSR=2, scn 2 -> port1 WRITE addr 0 data 0.
    pulse0();
    chk("r1_draw_busy", busy0, 1);
    chk("r1_draw_valid", v0, 0);
    cyc();
    chk("r1_valid", v0, 2'b10);
    chk("r1_code", c0, 6'h10);
    chk("r1_addr", a0, 4'h0);
    chk("r1_data", d0, 16'h0000);
    cyc();
    chk("r1_done", done0, 1);
    chk("r1_busy", busy0, 0);
    chk("r1_iter", it0, 1);
    chk("r1_done_valid", v0, 0);

    // Restart from DONE: LFSR continues to 4, scn 4 -> port0 READ; port1 READ.
    pulse0();
    chk("r2_iter_clr", it0, 0);
    chk("r2_done_clr", done0, 0);
    cyc();
    chk("r2_s0_valid", v0, 2'b01);
    chk("r2_s0_code", c0, 6'h01);
    cyc();
    chk("r2_s1_valid", v0, 2'b10);
    chk("r2_s1_code", c0, 6'h08);
    cyc();
    chk("r2_done", done0, 1);
    chk("r2_iter", it0, 1);

    // Directed scn 9: HOLD; RELEASE; B READ.
    mode_dir0 = 1'b1;
    dir_scn = 4'd9;
    dir_a_addr = 2'd2; dir_a_data = 8'h5A;
    dir_b_addr = 2'd1; dir_b_data = 8'hFF;
    pulse0();
    cyc();
    chk("d9_s0_valid", v0, 2'b01);
    chk("d9_s0_code", c0, 6'h03);
    chk("d9_s0_addr", a0, 4'h2);
    chk("d9_s0_data", d0, 16'h005A);
    cyc();
    chk("d9_s1_valid", v0, 2'b01);
    chk("d9_s1_code", c0, 6'h04);
    chk("d9_s1_addr", a0, 4'h2);
    cyc();
    chk("d9_s2_valid", v0, 2'b10);
    chk("d9_s2_code", c0, 6'h08);
    chk("d9_s2_addr", a0, 4'h4);
    chk("d9_s2_data", d0, 16'hFF00);
    chk("d9_s2_busy", busy0, 1);
    cyc();
    chk("d9_done", done0, 1);
    chk("d9_iter", it0, 1);
    chk("d9_end_valid", v0, 0);

    // Directed scn 9 with reset during the pending last step, then a fresh random start.
    pulse0();
    cyc();
    cyc();
    chk("rm_s1_code", c0, 6'h04);
    cyc();
    chk("rm_s2_valid", v0, 2'b10);
    rdy0 = 2'b00;
    reset = 1'b1;
    cyc();
    chk("rm_valid", v0, 0);
    chk("rm_code", c0, 0);
    chk("rm_busy", busy0, 0);
    chk("rm_done", done0, 0);
    chk("rm_iter", it0, 0);
    reset = 1'b0;
    rdy0 = 2'b11;
    mode_dir0 = 1'b0;
    pulse0();
    cyc();
    chk("rp_valid", v0, 2'b10);
    chk("rp_code", c0, 6'h10);
    chk("rp_addr", a0, 4'h0);
    chk("rp_data", d0, 16'h0000);
    cyc();
    chk("rp_done", done0, 1);

    // Directed scn 13 with port0 back-pressured for 3 cycles.
    mode_dir0 = 1'b1;
    dir_scn = 4'd13;
    dir_a_addr = 2'd3; dir_a_data = 8'h00;
    dir_b_addr = 2'd3; dir_b_data = 8'h11;
    rdy0 = 2'b10;
    pulse0();
    cyc();
    chk("d13_valid", v0, 2'b11);
    chk("d13_code", c0, 6'h12);
    chk("d13_addr", a0, 4'hF);
    chk("d13_data", d0, 16'h1100);
    for (int i = 0; i < 3; i++) begin
      cyc();
      if (i == 2) rdy0 = 2'b11;
      chk("d13_hold_valid", v0, 2'b01);
      chk("d13_hold_code", c0[2:0], 3'd2);
      chk("d13_hold_addr", a0[1:0], 2'd3);
      chk("d13_hold_data", d0[7:0], 8'h00);
      chk("d13_hold_busy", busy0, 1);
    end
    cyc();
    chk("d13_done", done0, 1);
    chk("d13_iter", it0, 1);
    chk("d13_end_valid", v0, 0);

    // Random run on the 4-port instance against a reference model, random ready.
    m = Seed1;
    abort = 1'b0;
    start1 = 1'b1;
    cyc();
    start1 = 1'b0;
    for (int it = 0; it < 200 && !abort; it++) begin
      chk("rnd_draw_valid", v1, 0);
      chk("rnd_draw_busy", busy1, 1);
      m = {m[62:0], m[63] ^ m[62] ^ m[60] ^ m[59]};
      scn = m[3:0];
      aa = m[5:4];   ad = map_data(m[7:6], m[15:8]);
      ba = m[17:16]; bd = map_data(m[19:18], m[27:20]);
      pa = m[29:28]; off = m[31:30];
      pb = pa ^ ((off == 2'd0) ? 2'd1 : off);
      tab = scn_tab(scn);
      nst = int'(tab[19:18]);
      cyc();
      for (int s = 0; s < nst && !abort; s++) begin
        ac = tab[s*6+3 +: 3];
        bc = tab[s*6 +: 3];
        ev = '0; ecode = '0; eaddr = '0; edata = '0;
        if (ac != N) begin
          ev[pa] = 1'b1; ecode[pa*3 +: 3] = ac; eaddr[pa*2 +: 2] = aa; edata[pa*8 +: 8] = ad;
        end
        if (bc != N) begin
          ev[pb] = 1'b1; ecode[pb*3 +: 3] = bc; eaddr[pb*2 +: 2] = ba; edata[pb*8 +: 8] = bd;
        end
        outm = ev;
        waitc = 0;
        while (outm != 4'd0) begin
          cm = '0; am = '0; dm = '0;
          for (int p = 0; p < 4; p++) begin
            if (outm[p]) begin
              cm[p*3 +: 3] = 3'h7; am[p*2 +: 2] = 2'h3; dm[p*8 +: 8] = 8'hFF;
            end
          end
          chk("rnd_valid", v1, outm);
          chk("rnd_code", c1 & cm, ecode & cm);
          chk("rnd_addr", a1 & am, eaddr & am);
          chk("rnd_data", d1 & dm, edata & dm);
          rdy1 = (waitc >= 16) ? 4'hF : 4'($urandom);
          cyc();
          outm = outm & ~rdy1;
          waitc++;
          if (waitc > 40) begin
            checks++;
            errors++;
            $display("FAIL rnd_step_timeout iter=%0d step=%0d", it, s);
            abort = 1'b1;
            break;
          end
        end
      end
    end
    chk("rnd_done", done1, 1);
    chk("rnd_iter", it1, 200);
    chk("rnd_busy", busy1, 0);
    chk("rnd_end_valid", v1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/csm_stim_gen.md
# csm_stim_gen

Synthesizable, parametrised stimulus sequencer for the CSM shared-memory DUT. It generalises the two-port random scenario generator to NPORTS ports and configurable address and data widths. It is driven by a 64-bit LFSR, and a directed mode replays one chosen scenario. It sits in front of the CSM port inputs and issues read, write, hold and release operations over a valid/ready handshake per port.

## Interface
- NPORTS, 2: number of CSM ports. Must be a power of two, 2..8.
- AW, 2: address width, 1..8.
- DW, 8: data width, 1..16.
- ITER, 1000: iterations per run, 1..65535.
- SEED, 64'h1: LFSR seed. A value of 0 is replaced by 64'h1.
- clk  in  1  clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begins a run; sampled in IDLE or DONE.
- mode_dir  in  1  selects directed mode; sampled in DRAW.
- dir_scn  in  4  directed scenario index.
- dir_a_addr / dir_b_addr  in  AW  directed addresses.
- dir_a_data / dir_b_data  in  DW  directed data.
- op_valid  out  NPORTS  per-port operation valid.
- op_ready  in  NPORTS  per-port accept.
- op_code  out  3*NPORTS  per port: 0 NOP, 1 READ, 2 WRITE, 3 HOLD, 4 RELEASE.
- op_addr  out  AW*NPORTS  per-port address.
- op_data  out  DW*NPORTS  per-port data.
- busy  out  1  high from DRAW through the last handshake.
- done  out  1  high in DONE.
- iter_count  out  16  completed iterations.

## Operation
- States are IDLE, DRAW, STEP, DONE. A step counter `s` runs 0..2.
- IDLE, or DONE with start=1: go to DRAW.
  - From IDLE, the LFSR keeps its current value.
  - From DONE, iter_count is cleared and the LFSR is not reseeded.
- LFSR: 64-bit Fibonacci, taps 64,63,61,60, shifts left with feedback into bit 0. It advances exactly once, in each DRAW.
- Fields are sliced from the post-advance value, starting at LSB:
  - scn[3:0]
  - a_addr (AW bits), a_cls (2 bits), a_rnd (DW bits)
  - b_addr (AW bits), b_cls (2 bits), b_rnd (DW bits)
  - pa (log2 NPORTS bits), off (log2 NPORTS bits)
- Data class mapping: cls 00 gives all-zeros; cls 01 gives all-ones; otherwise the raw rnd value.
- Port A is pa. Port B is pa XOR off, with off=0 forced to 1.
- Directed mode: scn=dir_scn, pa=0, pb=1, and addresses and data come from the dir_* inputs unmodified.
- Scenarios. ";" means sequential steps; "||" means both ops in the same step.
  - 0: A READ
  - 1: A WRITE
  - 2: B WRITE
  - 3: B READ
  - 4: A READ; B READ
  - 5: A READ; B WRITE
  - 6: A WRITE; B READ
  - 7: A HOLD || B READ
  - 8: B HOLD || A READ
  - 9: A HOLD; A RELEASE; B READ
  - 10: A READ; A READ
  - 11: A WRITE; A WRITE
  - 12: A WRITE; A READ
  - 13: A WRITE || B WRITE
  - 14: A HOLD || B HOLD
  - 15: A HOLD; B HOLD
- Every op carries its side's address and data. READ, HOLD and RELEASE carry data, which is don't-care to the DUT.
- Ports not used in a step drive op_valid=0, code NOP, and address and data 0.

## Timing
- Reset, in the cycle after the edge:
  - state IDLE, LFSR=SEED, iter_count=0.
  - all op_valid=0, op_code=NOP, op_addr=0, op_data=0.
  - busy=0, done=0.
- Reset mid-run has the same effect; any pending handshake is abandoned.
- If start is sampled at edge k: DRAW occupies cycle k+1, and the first step's op_valid is high in cycle k+2.
- Handshake:
  - op_valid, code, address and data are held stable until op_ready is sampled high.
  - That port's op_valid drops the next cycle.
  - Other ports in the same step stay valid until they are accepted individually.
- A step completes at the edge where its last outstanding op is accepted.
  - The next step's valids are high in the following cycle, with no bubble.
- At the final step's completion:
  - iter_count increments.
  - If iter_count reaches ITER, the block enters DONE (done=1, busy=0). Otherwise it enters DRAW.
- Per-iteration minimum cost with ready tied high: 1 DRAW cycle plus 1 cycle per step.
- op_ready on a port whose op_valid is 0 is ignored.

## Test plan
- Reset with ready=all-ones -> all outputs at reset values, and they hold for 5 cycles with start=0.
- Directed scn 9, A=(2,8'h5A), B=(1,8'hFF), ITER=1, ready high, start at edge k. Required response:
  - port0 HOLD addr 2 in cycle k+2.
  - port0 RELEASE addr 2 in cycle k+3.
  - port1 READ addr 1 in cycle k+4.
  - done=1 and iter_count=1 in cycle k+5.
- Directed scn 13, A=(3,8'h00), B=(3,8'h11). port0 ready held low for 3 cycles, port1 ready high. Required response:
  - port1 WRITE accepted in its first cycle, then port1 valid=0.
  - port0 WRITE is held stable for 3 more cycles.
  - The step ends at the edge where port0 is accepted.
- Random mode, NPORTS=4, ITER=200, random ready. Required response:
  - pb≠pa on every iteration.
  - Ops match a reference LFSR model bit-exactly.
  - iter_count reaches 200 and done=1.
- Reset asserted during step 2 of scn 9 -> all valids are 0 the next cycle. A fresh start replays the same first iteration as after power-on reset.
- DONE followed by a start pulse -> iter_count=0, and the LFSR continues without repeating the first run's first draw.
